// File: rtl/stm1_frame_sequencer_pkg.sv
// Shared constants, slot/state types and slot decode for the STM-1 frame sequencer.
// AU pointer offset is fixed at 0, so VC4 POH always sits in column 9.
package stm1_frame_sequencer_pkg;

   localparam int STM1_LEN     = 270;
   localparam int STM1_ROWS    = 9;
   localparam int STM1_OH_COLS = 9;
   localparam int POH_COL      = 9;
   localparam int PTR_ROW      = 3;
   localparam int RSOH_ROWS    = 3;
   localparam int STM1_BYTES   = STM1_LEN * STM1_ROWS;

   localparam logic [7:0] FILL_BYTE = 8'h00;

   typedef enum logic [1:0] {
      SLOT_SOH,
      SLOT_PTR,
      SLOT_POH,
      SLOT_PAYLOAD
   } slot_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOP_PEND
   } state_t;

   // Rows 0..2 are RSOH, row 3 carries the AU pointer, rows 4..8 are MSOH.
   function automatic slot_t slot_of(input logic [3:0] row, input logic [8:0] col);
      slot_t s;
      if (col < 9'(STM1_OH_COLS)) begin
         if (row < 4'(RSOH_ROWS))
            s = SLOT_SOH;
         else if (row == 4'(PTR_ROW))
            s = SLOT_PTR;
         else
            s = SLOT_SOH;
      end else if (col == 9'(POH_COL)) begin
         s = SLOT_POH;
      end else begin
         s = SLOT_PAYLOAD;
      end
      return s;
   endfunction

endpackage

// File: rtl/stm1_frame_sequencer_pos_counter.sv
// Row/column/multiframe position counter for one STM-1 frame (270 x 9 bytes).
// last_o flags the final byte slot (row 8, col 269) of the frame.
module stm1_pos_counter
   import stm1_frame_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance_i,
   input  logic       clear_i,
   output logic [3:0] row_o,
   output logic [8:0] col_o,
   output logic [1:0] mfi_o,
   output logic       last_o
);

   logic [3:0] row_q, row_d;
   logic [8:0] col_q, col_d;
   logic [1:0] mfi_q, mfi_d;
   logic       col_wrap;
   logic       row_wrap;

   assign col_wrap = (col_q == 9'(STM1_LEN - 1));
   assign row_wrap = (row_q == 4'(STM1_ROWS - 1));

   // Clear only rewinds the position; the multiframe index keeps counting.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      mfi_d = mfi_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
      end else if (advance_i) begin
         if (col_wrap) begin
            col_d = '0;
            if (row_wrap) begin
               row_d = '0;
               mfi_d = mfi_q + 2'd1;
            end else begin
               row_d = row_q + 4'd1;
            end
         end else begin
            col_d = col_q + 9'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
         mfi_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         mfi_q <= mfi_d;
      end
   end

   assign row_o  = row_q;
   assign col_o  = col_q;
   assign mfi_o  = mfi_q;
   assign last_o = col_wrap && row_wrap;

endmodule

// File: rtl/stm1_frame_sequencer.sv
// Byte-serial STM-1 frame builder: picks SOH/PTR, POH or C4 payload for each slot
// and presents framed bytes downstream with a registered valid/ready output stage.
module stm1_frame_sequencer
   import stm1_frame_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop_req,
   input  logic [7:0] oh_data,
   input  logic [7:0] poh_data,
   input  logic [7:0] c4_data,
   input  logic       c4_valid,
   output logic       c4_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_slot,
   output logic [3:0] out_row,
   output logic [8:0] out_col,
   output logic       out_sof,
   output logic [3:0] oh_row,
   output logic [8:0] oh_col,
   output logic [1:0] mfi,
   output logic       busy,
   output logic       underflow,
   output logic [1:0] dbg_state
);

   // Handshake: a byte transfers on any cycle where valid and ready are both high.
   // out_valid/out_data never change while out_valid=1 and out_ready=0; c4_data
   // is consumed in the cycle c4_valid and c4_ready are both high.

   state_t     state_q;
   logic [7:0] out_data_q;
   logic       out_valid_q;
   slot_t      out_slot_q;
   logic [3:0] out_row_q;
   logic [8:0] out_col_q;
   logic       out_sof_q;
   logic       underflow_q;

   logic [3:0] pos_row;
   logic [8:0] pos_col;
   logic       pos_last;
   logic       emit;
   slot_t      cur_slot;
   logic [7:0] byte_d;
   logic       starve;

   assign emit     = (state_q != ST_IDLE) && (!out_valid_q || out_ready);
   assign cur_slot = slot_of(pos_row, pos_col);

   stm1_pos_counter u_pos (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (emit),
      .clear_i   (state_q == ST_IDLE),
      .row_o     (pos_row),
      .col_o     (pos_col),
      .mfi_o     (mfi),
      .last_o    (pos_last)
   );

   always_comb begin
      byte_d = FILL_BYTE;
      starve = 1'b0;
      case (cur_slot)
         SLOT_SOH,
         SLOT_PTR:     byte_d = oh_data;
         SLOT_POH:     byte_d = poh_data;
         SLOT_PAYLOAD: begin
            if (c4_valid)
               byte_d = c4_data;
            else
               starve = 1'b1;
         end
         default:      byte_d = FILL_BYTE;
      endcase
   end

   // stop_req takes priority over start while running; start is ignored once stopping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_slot_q  <= SLOT_SOH;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_sof_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_RUN;
                  underflow_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (stop_req)
                  state_q <= ST_STOP_PEND;
            end
            ST_STOP_PEND: begin
               if (emit && pos_last)
                  state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase

         if (emit) begin
            out_valid_q <= 1'b1;
            out_data_q  <= byte_d;
            out_slot_q  <= cur_slot;
            out_row_q   <= pos_row;
            out_col_q   <= pos_col;
            out_sof_q   <= (pos_row == 4'd0) && (pos_col == 9'd0);
            if (starve)
               underflow_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign c4_ready  = emit && (cur_slot == SLOT_PAYLOAD);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_slot  = out_slot_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;
   assign out_sof   = out_sof_q;
   assign oh_row    = pos_row;
   assign oh_col    = pos_col;
   assign busy      = (state_q != ST_IDLE);
   assign underflow = underflow_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_stm1_frame_sequencer.sv
// Directed bench for stm1_frame_sequencer: framing layout, underflow fill,
// backpressure, stop-after-frame, multiframe index and asynchronous reset.
module tb_stm1_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop_req = 1'b0;
   logic       c4_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] oh_data, poh_data, c4_data, out_data;
   logic       c4_ready, out_valid, out_sof, busy, underflow;
   logic [1:0] out_slot, mfi, dbg_state;
   logic [3:0] out_row, oh_row;
   logic [8:0] out_col, oh_col;

   always #5 clk = ~clk;

   stm1_frame_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop_req  (stop_req),
      .oh_data   (oh_data),
      .poh_data  (poh_data),
      .c4_data   (c4_data),
      .c4_valid  (c4_valid),
      .c4_ready  (c4_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_slot  (out_slot),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_sof   (out_sof),
      .oh_row    (oh_row),
      .oh_col    (oh_col),
      .mfi       (mfi),
      .busy      (busy),
      .underflow (underflow),
      .dbg_state (dbg_state)
   );

   // Overhead "ROMs" addressed by the DUT's next-slot position.
   assign oh_data  = {1'b1, oh_row[2:0], oh_col[3:0]};
   assign poh_data = {4'hC, oh_row};

   // Payload source: incrementing bytes, each popped byte goes to the expected queue.
   logic [7:0] c4_cnt = 8'h01;
   logic [7:0] exp_q[$];
   assign c4_data = c4_cnt;

   always @(posedge clk) begin
      if (c4_valid && c4_ready) begin
         exp_q.push_back(c4_cnt);
         c4_cnt <= c4_cnt + 8'd1;
      end
   end

   typedef struct {
      logic [7:0] data;
      logic [1:0] slot;
      logic [3:0] row;
      logic [8:0] col;
      logic       sof;
      logic [1:0] mfi;
   } cap_t;

   cap_t cap_q[$];
   cap_t cap_v;
   int   c4_pulses = 0;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         cap_v.data = out_data;
         cap_v.slot = out_slot;
         cap_v.row  = out_row;
         cap_v.col  = out_col;
         cap_v.sof  = out_sof;
         cap_v.mfi  = mfi;
         cap_q.push_back(cap_v);
      end
      if (c4_ready)
         c4_pulses++;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int exp_rd  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pos(input string tag, input int r, input int c, input int budget);
      int n = 0;
      while (!(oh_row == 4'(r) && oh_col == 9'(c)) && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, 32'(oh_row == 4'(r) && oh_col == 9'(c)), 32'd1);
   endtask

   task automatic wait_caps(input string tag, input int target, input int budget);
      int n = 0;
      while (cap_q.size() < target && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, 32'(cap_q.size() >= target), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((busy || out_valid) && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, {30'd0, busy, out_valid}, 32'd0);
   endtask

   // Re-derive every captured byte from its frame index and compare.
   task automatic analyze(input string tag, input int base, input int nfr, input bit fill_en,
                          input int fill_row, input int fill_c0, input int fill_n);
      int total, got, p, er, ec;
      int pos_err, slot_err, sof_err, data_err;
      int n_soh, n_ptr, n_poh, n_pay;
      logic [1:0] es;
      logic [7:0] eb;
      cap_t c;
      total = nfr * 2430;
      got = cap_q.size() - base;
      pos_err = 0; slot_err = 0; sof_err = 0; data_err = 0;
      n_soh = 0; n_ptr = 0; n_poh = 0; n_pay = 0;
      check_eq({tag, "_bytes"}, 32'(got), 32'(total));
      for (int i = 0; i < total && base + i < cap_q.size(); i++) begin
         c  = cap_q[base + i];
         p  = i % 2430;
         er = p / 270;
         ec = p % 270;
         if (ec < 9)       es = (er == 3) ? 2'd1 : 2'd0;
         else if (ec == 9) es = 2'd2;
         else              es = 2'd3;
         if (c.row != 4'(er) || c.col != 9'(ec)) pos_err++;
         if (c.slot != es) slot_err++;
         if (c.sof != (p == 0)) sof_err++;
         case (c.slot)
            2'd0: n_soh++;
            2'd1: n_ptr++;
            2'd2: n_poh++;
            default: n_pay++;
         endcase
         if (es == 2'd3) begin
            if (fill_en && i < 2430 && er == fill_row && ec >= fill_c0 && ec < fill_c0 + fill_n) begin
               eb = 8'h00;
            end else if (exp_rd < exp_q.size()) begin
               eb = exp_q[exp_rd];
               exp_rd++;
            end else begin
               eb = ~c.data;
            end
         end else if (es == 2'd2) begin
            eb = {4'hC, 4'(er)};
         end else begin
            eb = {1'b1, 3'(er), 4'(ec)};
         end
         if (c.data != eb) data_err++;
      end
      check_eq({tag, "_pos_err"},  32'(pos_err),  32'd0);
      check_eq({tag, "_slot_err"}, 32'(slot_err), 32'd0);
      check_eq({tag, "_sof_err"},  32'(sof_err),  32'd0);
      check_eq({tag, "_data_err"}, 32'(data_err), 32'd0);
      check_eq({tag, "_n_soh"},    32'(n_soh),    32'(72 * nfr));
      check_eq({tag, "_n_ptr"},    32'(n_ptr),    32'(9 * nfr));
      check_eq({tag, "_n_poh"},    32'(n_poh),    32'(9 * nfr));
      check_eq({tag, "_n_pay"},    32'(n_pay),    32'(2340 * nfr));
      check_eq({tag, "_exp_left"}, 32'(exp_q.size() - exp_rd), 32'd0);
   endtask

   initial begin
      int base, pbase, diffs;
      logic [7:0] s_data;
      logic [3:0] s_row;
      logic [8:0] s_col;

      // ---- reset state ----
      out_ready = 1'b1;
      c4_valid  = 1'b1;
      repeat (3) step();
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_busy",      32'(busy),      32'd0);
      check_eq("rst_c4_ready",  32'(c4_ready),  32'd0);
      check_eq("rst_mfi",       32'(mfi),       32'd0);
      check_eq("rst_underflow", 32'(underflow), 32'd0);
      check_eq("rst_state",     32'(dbg_state), 32'd0);
      rst_n = 1'b1;
      step();

      // ---- frame 1: layout, latency, stop at row 2 col 100 ----
      base  = cap_q.size();
      pbase = c4_pulses;
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("f1_busy",          32'(busy),      32'd1);
      check_eq("f1_state_run",     32'(dbg_state), 32'd1);
      check_eq("f1_no_valid_yet",  32'(out_valid), 32'd0);
      step();
      check_eq("f1_first_valid",   32'(out_valid), 32'd1);
      check_eq("f1_first_sof",     32'(out_sof),   32'd1);
      check_eq("f1_first_slot",    32'(out_slot),  32'd0);
      check_eq("f1_first_pos",     {19'd0, out_row, out_col}, 32'd0);
      check_eq("f1_first_data",    32'(out_data),  32'h80);
      wait_pos("f1_reach_r2c100", 2, 100, 1000);
      stop_req = 1'b1;
      step();
      stop_req = 1'b0;
      check_eq("f1_state_stop",    32'(dbg_state), 32'd2);
      wait_idle("f1_idle", 3000);
      check_eq("f1_mfi",           32'(mfi),       32'd1);
      check_eq("f1_pos_home",      {19'd0, oh_row, oh_col}, 32'd0);
      check_eq("f1_c4_pulses",     32'(c4_pulses - pbase), 32'd2340);
      if (base + 810 < cap_q.size()) begin
         check_eq("f1_r3c0_slot",  32'(cap_q[base + 810].slot), 32'd1);
         check_eq("f1_r3c0_data",  32'(cap_q[base + 810].data), 32'hB0);
         check_eq("f1_r0c9_slot",  32'(cap_q[base + 9].slot),   32'd2);
         check_eq("f1_r0c9_data",  32'(cap_q[base + 9].data),   32'hC0);
         check_eq("f1_r0c10_data", 32'(cap_q[base + 10].data),  32'h01);
      end else begin
         check_eq("f1_capture_count", 32'(cap_q.size() - base), 32'd2430);
      end
      analyze("f1", base, 1, 1'b0, 0, 0, 0);

      // ---- frame 2: underflow fill and backpressure ----
      base  = cap_q.size();
      pbase = c4_pulses;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check_eq("f2_sof",       32'(out_sof), 32'd1);
      check_eq("f2_start_pos", {19'd0, out_row, out_col}, 32'd0);
      check_eq("f2_mfi",       32'(mfi),     32'd1);
      check_eq("f2_uf_clear",  32'(underflow), 32'd0);
      wait_pos("f2_reach_r1c20", 1, 20, 1000);
      c4_valid = 1'b0;
      repeat (5) step();
      c4_valid = 1'b1;
      check_eq("f2_uf_set", 32'(underflow), 32'd1);
      wait_pos("f2_reach_r4c50", 4, 50, 2000);
      out_ready = 1'b0;
      #1;
      check_eq("f2_stall_c4_ready", 32'(c4_ready), 32'd0);
      check_eq("f2_stall_out_pos",  {19'd0, out_row, out_col}, {19'd0, 4'd4, 9'd49});
      s_data = out_data;
      s_row  = out_row;
      s_col  = out_col;
      pbase  = pbase + (c4_pulses - pbase);
      diffs  = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_data != s_data || out_row != s_row || out_col != s_col ||
             oh_col != 9'd50 || !out_valid)
            diffs++;
      end
      check_eq("f2_stall_hold",    32'(diffs), 32'd0);
      check_eq("f2_stall_no_pop",  32'(c4_pulses - pbase), 32'd0);
      out_ready = 1'b1;
      check_eq("f2_uf_sticky", 32'(underflow), 32'd1);
      stop_req = 1'b1;
      step();
      stop_req = 1'b0;
      wait_idle("f2_idle", 3000);
      check_eq("f2_mfi_end", 32'(mfi), 32'd2);
      analyze("f2", base, 1, 1'b1, 1, 20, 5);

      // ---- asynchronous reset mid-frame ----
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("f3_uf_clear_on_start", 32'(underflow), 32'd0);
      wait_pos("f3_reach_r5c0", 5, 0, 3000);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ar_out_valid", 32'(out_valid), 32'd0);
      check_eq("ar_out_data",  32'(out_data),  32'd0);
      check_eq("ar_out_slot",  32'(out_slot),  32'd0);
      check_eq("ar_out_pos",   {19'd0, out_row, out_col}, 32'd0);
      check_eq("ar_out_sof",   32'(out_sof),   32'd0);
      check_eq("ar_busy",      32'(busy),      32'd0);
      check_eq("ar_c4_ready",  32'(c4_ready),  32'd0);
      check_eq("ar_mfi",       32'(mfi),       32'd0);
      check_eq("ar_oh_pos",    {19'd0, oh_row, oh_col}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      exp_rd = exp_q.size();

      // ---- five frames after reset: mfi 0,1,2,3,0 ----
      base  = cap_q.size();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check_eq("f5_first_sof", 32'(out_sof), 32'd1);
      check_eq("f5_first_pos", {19'd0, out_row, out_col}, 32'd0);
      wait_caps("f5_reach_frame5", base + 4 * 2430 + 1, 12000);
      stop_req = 1'b1;
      step();
      stop_req = 1'b0;
      wait_idle("f5_idle", 3000);
      for (int k = 0; k < 5; k++) begin
         if (base + k * 2430 < cap_q.size())
            check_eq($sformatf("f5_mfi_seq%0d", k), 32'(cap_q[base + k * 2430].mfi), 32'(k % 4));
         else
            check_eq($sformatf("f5_mfi_seq%0d_missing", k), 32'(cap_q.size() - base), 32'(5 * 2430));
      end
      check_eq("f5_mfi_end", 32'(mfi), 32'd1);
      analyze("f5", base, 5, 1'b0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stm1_frame_sequencer.md
Name: stm1_frame_sequencer

Overview:
- Byte-serial scheduler that builds STM-1 frames (270 cols x 9 rows = 2430 bytes) from three sources: section overhead, VC4 path overhead and the C4 payload stream (260 x 9).
- Owns the row/column position, chooses the source for every byte slot, pulls C4 bytes through a valid/ready handshake, and presents each framed byte downstream with valid/ready.
- Sits between the C4 mapper FIFO and the STM-1 serializer.
- AU pointer offset is fixed at 0: VC4 POH occupies column 9.

Parameters:
- STM1_LEN, 270, columns per STM-1 row (from param_pkg STM1_Lenght).
- STM1_ROWS, 9, rows per frame (param_pkg STM1_Width).
- OH_COLS, 9, SOH/pointer columns (0..8).
- FILL_BYTE, 8'h00, byte inserted on payload underflow.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin framing (level or pulse, sampled each cycle).
- stop_req, in, 1, stop after the current frame completes.
- oh_data, in, 8, SOH/pointer byte for the slot currently being emitted.
- poh_data, in, 8, POH byte for the current slot.
- c4_data, in, 8, C4 payload byte.
- c4_valid, in, 1, c4_data valid.
- c4_ready, out, 1, payload byte consumed this cycle.
- out_data, out, 8, framed byte.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accepts.
- out_slot, out, 2, 0=SOH, 1=PTR, 2=POH, 3=PAYLOAD.
- out_row, out, 4, row of emitted byte.
- out_col, out, 9, column of emitted byte.
- out_sof, out, 1, emitted byte is row 0 col 0.
- oh_row/oh_col, out, 4/9, position of the next slot (address for oh_data/poh_data lookup).
- mfi, out, 2, multiframe index, increments at each frame wrap.
- busy, out, 1, state != IDLE.
- underflow, out, 1, sticky; cleared on start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; position row=0, col=0; mfi=0.
  - out_valid=0, out_data=0, out_slot=0, out_row=0, out_col=0, out_sof=0.
  - underflow=0, c4_ready=0, busy=0.
  - An in-progress frame is discarded.
- States:
  - IDLE -> RUN on start (stop_req ignored in IDLE).
  - RUN -> STOP_PEND on stop_req. stop_req and start together in RUN: stop_req wins.
  - STOP_PEND -> IDLE in the cycle the last byte (row 8, col 269) is emitted; position returns to 0,0.
  - start in STOP_PEND is ignored.
- emit = (RUN or STOP_PEND) and (!out_valid or out_ready). On emit, all out_* registers load from the current position (1-cycle latency) and the position advances. On no emit, out_* hold (stable under backpressure).
- Slot classification:
  - col<9: row<3 -> SOH, row==3 -> PTR, row>=4 -> SOH.
  - col==9 -> POH.
  - else -> PAYLOAD.
- Data mux: SOH/PTR -> oh_data; POH -> poh_data; PAYLOAD -> c4_data if c4_valid, else FILL_BYTE and underflow<=1.
- c4_ready = emit and slot==PAYLOAD (combinational); the upstream FIFO pops only on c4_valid & c4_ready.
- Position wrap: col 269 -> 0 with row+1; row 8 col 269 -> 0,0 and mfi+1 (mod 4).
- IDLE: out_valid clears once its byte is accepted (out_ready); no new emit.
- Per frame: 81 SOH/PTR bytes (72 SOH + 9 PTR), 9 POH bytes, 2340 payload bytes.

Decomposition:
- param_pkg gains:
  - typedef enum logic[1:0] slot_t {SLOT_SOH, SLOT_PTR, SLOT_POH, SLOT_PAYLOAD}.
  - STM1_OH_COLS=9, POH_COL=9, PTR_ROW=3, RSOH_ROWS=3, STM1_BYTES=2430.
- Sub-module stm1_pos_counter: row/col/mfi counter with advance/clear inputs and last-of-frame flag. Slot decode and FSM stay in the top.

Test Plan:
- Reset then start with out_ready=1, c4_valid=1 -> first out_valid after 1 cycle with out_sof=1, slot SOH; exactly 2430 bytes per frame, 2340 c4_ready pulses, byte at row 3 col 0 slot=PTR, col 9 slot=POH.
- c4_valid low for 5 payload slots -> 5 bytes of 8'h00, underflow=1 sticky; next start clears it.
- out_ready held low 10 cycles mid-payload -> out_data/out_row/out_col stable, c4_ready=0, no position advance; resumes without loss or duplication.
- stop_req at row 2 col 100 -> frame completes to row 8 col 269, busy drops, next start begins at row 0 col 0 with mfi incremented.
- Four full frames -> mfi sequence 0,1,2,3,0.
- rst_n low mid-frame (row 5) -> all outputs 0 immediately; after release, start yields out_sof on first byte.
